sr_ff_bank: RTL and testbench

SR_FF_BANK -- requirements
Module: sr_ff_bank

---
 rtl/sr_ff_bank.sv | 75 +++++++
 tb/tb_sr_ff_bank.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/sr_ff_bank.sv
// Bank of WIDTH independent, registered SR flip-flops with selectable S&R conflict policy.
// Optional saturating conflict counter, compiled in only when SR_FF_BANK_CNT_EN is defined.
module sr_ff_bank #(
    parameter int               WIDTH   = 8,
    parameter int               MODE    = 0,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_n,
    output logic [WIDTH-1:0] conflict,
    output logic [15:0]      conflict_cnt
);

    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("sr_ff_bank: WIDTH must be in 1..32");
        end
        if (MODE < 0 || MODE > 3) begin : g_bad_mode
            $error("sr_ff_bank: MODE must be in 0..3");
        end
    endgenerate

    logic [WIDTH-1:0] both;
    logic [WIDTH-1:0] conf_val;
    logic [WIDTH-1:0] q_next;

    // Non-conflicting channels follow plain SR rules; conflicting ones take conf_val.
    always_comb begin
        both = S & R;
        case (MODE)
            0:       conf_val = {WIDTH{1'b1}};
            1:       conf_val = {WIDTH{1'b0}};
            3:       conf_val = ~Q;
            default: conf_val = Q;
        endcase
        q_next = ((Q | (S & ~R)) & ~(R & ~S) & ~both) | (both & conf_val);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Q        <= RST_VAL;
            conflict <= '0;
        end else if (en) begin
            Q        <= q_next;
            conflict <= both;
        end else begin
            conflict <= '0;
        end
    end

    // Derived from the register alone, so Q_n can never disagree with Q.
    assign Q_n = ~Q;

`ifdef SR_FF_BANK_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (en && (|both) && (cnt_q != 16'hFFFF)) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign conflict_cnt = cnt_q;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_sr_ff_bank.sv
// Self-checking bench for sr_ff_bank: one instance per conflict MODE, shared stimulus,
// per-bit reference model feeding an expected-value queue compared after each edge.
module tb_sr_ff_bank;

    localparam logic [7:0] RST_V = 8'hA5;
    localparam int         EW    = 4 * 8 + 8 + 16;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] s_in;
    logic [7:0] r_in;

    logic [7:0]  q_o   [4];
    logic [7:0]  qn_o  [4];
    logic [7:0]  cf_o  [4];
    logic [15:0] cnt_o [4];

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : g_dut
            sr_ff_bank #(
                .WIDTH   (8),
                .MODE    (g),
                .RST_VAL (RST_V)
            ) u_dut (
                .clk          (clk),
                .rst          (rst),
                .en           (en),
                .S            (s_in),
                .R            (r_in),
                .Q            (q_o[g]),
                .Q_n          (qn_o[g]),
                .conflict     (cf_o[g]),
                .conflict_cnt (cnt_o[g])
            );
        end
    endgenerate

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard state
    logic [EW-1:0] exp_q[$];
    int            checks = 0;
    int            errors = 0;

    logic [7:0]  m_q [4];
    logic [7:0]  m_cf;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: evaluated bit by bit, pushed as the expected result of this edge.
    task automatic model_edge(input logic [7:0] s, input logic [7:0] r, input logic e, input logic rs);
        for (int m = 0; m < 4; m++) begin
            for (int b = 0; b < 8; b++) begin
                if (rs) m_q[m][b] = RST_V[b];
                else if (e) begin
                    if (s[b] && !r[b]) m_q[m][b] = 1'b1;
                    else if (!s[b] && r[b]) m_q[m][b] = 1'b0;
                    else if (s[b] && r[b]) begin
                        if (m == 0) m_q[m][b] = 1'b1;
                        else if (m == 1) m_q[m][b] = 1'b0;
                        else if (m == 3) m_q[m][b] = ~m_q[m][b];
                    end
                end
            end
        end
        if (rs || !e) m_cf = 8'h00;
        else m_cf = s & r;
`ifdef SR_FF_BANK_CNT_EN
        if (rs) m_cnt = 16'h0000;
        else if (e && ((s & r) != 8'h00) && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
`else
        m_cnt = 16'h0000;
`endif
        exp_q.push_back({m_q[3], m_q[2], m_q[1], m_q[0], m_cf, m_cnt});
    endtask

    // Driver: apply inputs away from the edge, clock once, then compare against the queue head.
    task automatic step(input logic [7:0] s, input logic [7:0] r, input logic e, input logic rs);
        logic [EW-1:0] exp;
        logic [7:0]    eq;
        s_in = s;
        r_in = r;
        en   = e;
        rst  = rs;
        model_edge(s, r, e, rs);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 32'd1, 32'd0);
        end else begin
            exp = exp_q.pop_front();
            for (int m = 0; m < 4; m++) begin
                eq = exp[24 + 8*m +: 8];
                check($sformatf("q_m%0d", m), {24'd0, q_o[m]}, {24'd0, eq});
                check($sformatf("qn_m%0d", m), {24'd0, qn_o[m]}, {24'd0, ~eq});
                check($sformatf("conflict_m%0d", m), {24'd0, cf_o[m]}, {24'd0, exp[23:16]});
                check($sformatf("cnt_m%0d", m), {16'd0, cnt_o[m]}, {16'd0, exp[15:0]});
            end
        end
        #3;
    endtask

    initial begin
        rst  = 1'b1;
        en   = 1'b0;
        s_in = 8'h00;
        r_in = 8'h00;
        m_cf = 8'h00;
        m_cnt = 16'h0000;
        for (int m = 0; m < 4; m++) m_q[m] = 8'h00;
        @(negedge clk);

        // Reset load, overriding en/S/R
        step(8'hFF, 8'h00, 1'b1, 1'b1);
        check("reset_q", {24'd0, q_o[0]}, 32'h0000_00A5);
        check("reset_qn", {24'd0, qn_o[0]}, 32'h0000_005A);
        check("reset_cnt", {16'd0, cnt_o[0]}, 32'd0);

        // Set / reset / enable gating from Q=0
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        step(8'h0F, 8'h00, 1'b1, 1'b0);
        check("set_0f", {24'd0, q_o[0]}, 32'h0000_000F);
        step(8'h00, 8'h03, 1'b1, 1'b0);
        check("reset_03", {24'd0, q_o[1]}, 32'h0000_000C);
        step(8'hFF, 8'h00, 1'b0, 1'b0);
        check("en_gate", {24'd0, q_o[2]}, 32'h0000_000C);
        step(8'h00, 8'h00, 1'b1, 1'b0);

        // Conflict modes from Q[0]=0, then en=0 clears the flags
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        step(8'h01, 8'h01, 1'b1, 1'b0);
        check("mode0_q0", {31'd0, q_o[0][0]}, 32'd1);
        check("mode1_q0", {31'd0, q_o[1][0]}, 32'd0);
        check("mode2_q0", {31'd0, q_o[2][0]}, 32'd0);
        check("mode3_q0", {31'd0, q_o[3][0]}, 32'd1);
        check("conflict_01", {24'd0, cf_o[2]}, 32'h0000_0001);
        step(8'hFF, 8'hFF, 1'b0, 1'b0);

        // MODE3 toggle train from a fresh reset
        step(8'h00, 8'h00, 1'b0, 1'b1);
        step(8'h00, 8'hFF, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step(8'h01, 8'h01, 1'b1, 1'b0);
            check($sformatf("toggle_%0d", k), {31'd0, q_o[3][0]}, (k % 2 == 0) ? 32'd1 : 32'd0);
        end
`ifdef SR_FF_BANK_CNT_EN
        check("toggle_cnt", {16'd0, cnt_o[3]}, 32'd4);
`endif

        // Reset mid-toggle, then a 0/0 edge holds RST_VAL
        for (int k = 0; k < 3; k++) step(8'h01, 8'h01, 1'b1, 1'b0);
        step(8'h01, 8'h01, 1'b1, 1'b1);
        step(8'h00, 8'h00, 1'b1, 1'b0);
        check("mid_rst_q", {24'd0, q_o[3]}, 32'h0000_00A5);
        check("mid_rst_cnt", {16'd0, cnt_o[3]}, 32'd0);

        // Random traffic with occasional reset and disabled edges
        for (int k = 0; k < 300; k++) begin
            step(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 29) == 0));
        end

        // Counter saturation (or stays zero without the counter)
        step(8'h00, 8'h00, 1'b0, 1'b1);
`ifdef SR_FF_BANK_CNT_EN
        for (int k = 0; k < 65537; k++) step(8'h01, 8'h01, 1'b1, 1'b0);
        check("cnt_sat", {16'd0, cnt_o[0]}, 32'h0000_FFFF);
        for (int k = 0; k < 4; k++) step(8'h80, 8'h80, 1'b1, 1'b0);
        check("cnt_sat_hold", {16'd0, cnt_o[1]}, 32'h0000_FFFF);
`else
        for (int k = 0; k < 40; k++) step(8'h01, 8'h01, 1'b1, 1'b0);
        check("cnt_off", {16'd0, cnt_o[0]}, 32'd0);
`endif

        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
